// File: rtl/pwm_pkg.sv
// rtl/pwm_pkg.sv - shared widths, state encoding and default parameters for the PWM duty ramp controller
package pwm_pkg;

  // Width of TCR, CCR and the duty command
  localparam int CW = 7;

  // Default build parameters
  localparam int DEF_PERIOD   = 100;
  localparam int DEF_STEP     = 1;
  localparam int DEF_PRESCALE = 1;

  // Ramp controller states
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RAMP = 2'd1,
    STOP = 2'd2
  } state_t;

endpackage

// File: rtl/pwm_timebase.sv
// rtl/pwm_timebase.sv - free-running PWM timer with optional prescaler (macro PWM_PRESCALE_EN)
module pwm_timebase
  import pwm_pkg::*;
#(
  parameter int PERIOD   = DEF_PERIOD,
  parameter int PRESCALE = DEF_PRESCALE
) (
  input  logic          clk,
  input  logic          rst,
  output logic [CW-1:0] tcr,
  output logic          e,
  output logic          boundary
);

  localparam logic [CW-1:0] TCR_LAST = CW'(PERIOD - 1);

  // Reject parameter values the 7-bit timer and 8-bit prescaler cannot represent
  if (PERIOD < 2 || PERIOD > 127) begin : g_bad_period
    $error("pwm_timebase: PERIOD out of range");
  end
  if (PRESCALE < 1 || PRESCALE > 255) begin : g_bad_prescale
    $error("pwm_timebase: PRESCALE out of range");
  end

  logic tick;

`ifdef PWM_PRESCALE_EN
  localparam logic [7:0] PRE_LAST = 8'(PRESCALE - 1);

  logic [7:0] pre;

  assign tick = (pre == PRE_LAST);

  // Prescale counter: one tick every PRESCALE clocks, wrapping on the tick
  always_ff @(posedge clk) begin
    if (rst) begin
      pre <= 8'd0;
    end else if (tick) begin
      pre <= 8'd0;
    end else begin
      pre <= pre + 8'd1;
    end
  end
`else
  assign tick = 1'b1;
`endif

  // Timer count: advances on each tick, wraps PERIOD-1 -> 0, holds between ticks
  always_ff @(posedge clk) begin
    if (rst) begin
      tcr <= '0;
    end else if (tick) begin
      if (tcr == TCR_LAST) begin
        tcr <= '0;
      end else begin
        tcr <= tcr + 7'd1;
      end
    end
  end

  // E is held for every clock of TCR==0; the boundary is the single last-count tick
  assign e        = (tcr == '0);
  assign boundary = tick && (tcr == TCR_LAST);

endmodule

// File: rtl/pwm_duty_ramp_ctrl.sv
// rtl/pwm_duty_ramp_ctrl.sv - PWM duty ramp sequencer with emergency stop (optional prescaler via PWM_PRESCALE_EN)
module pwm_duty_ramp_ctrl
  import pwm_pkg::*;
#(
  parameter int PERIOD   = DEF_PERIOD,
  parameter int STEP     = DEF_STEP,
  parameter int PRESCALE = DEF_PRESCALE
) (
  input  logic          CLK,
  input  logic          RST,
  input  logic          CMD_VALID,
  output logic          CMD_READY,
  input  logic [CW-1:0] CMD_DUTY,
  input  logic          ESTOP,
  output logic [CW-1:0] TCR,
  output logic          E,
  output logic [CW-1:0] CCR,
  output logic          BUSY,
  output logic          DONE
);

  localparam logic [7:0]    PERIOD8  = 8'(PERIOD);
  localparam logic [7:0]    STEP8    = 8'(STEP);
  localparam logic [CW-1:0] PERIOD_C = CW'(PERIOD);

  if (STEP < 1 || STEP > PERIOD) begin : g_bad_step
    $error("pwm_duty_ramp_ctrl: STEP out of range");
  end

  state_t        state;
  state_t        state_nx;
  logic [CW-1:0] target;
  logic          boundary;
  logic          accept;
  logic          near;
  logic [7:0]    ccr8;
  logic [7:0]    tgt8;
  logic [7:0]    diff8;
  logic [CW-1:0] duty_clamped;

  pwm_timebase #(
    .PERIOD   (PERIOD),
    .PRESCALE (PRESCALE)
  ) u_timebase (
    .clk      (CLK),
    .rst      (RST),
    .tcr      (TCR),
    .e        (E),
    .boundary (boundary)
  );

  // 8-bit arithmetic so CCR+STEP cannot wrap before it is compared or clamped
  assign ccr8         = {1'b0, CCR};
  assign tgt8         = {1'b0, target};
  assign diff8        = (tgt8 >= ccr8) ? (tgt8 - ccr8) : (ccr8 - tgt8);
  assign near         = (diff8 <= STEP8);
  assign duty_clamped = ({1'b0, CMD_DUTY} > PERIOD8) ? PERIOD_C : CMD_DUTY;
  assign accept       = CMD_VALID && CMD_READY;

  // State register
  always_ff @(posedge CLK) begin
    if (RST) begin
      state <= IDLE;
    end else begin
      state <= state_nx;
    end
  end

  // Next-state: ESTOP overrides everything; ramp and stop exits wait for a boundary
  always_comb begin
    state_nx = state;
    if (ESTOP) begin
      state_nx = STOP;
    end else begin
      case (state)
        IDLE: if (accept) state_nx = RAMP;
        RAMP: if (boundary && near) state_nx = IDLE;
        STOP: if (boundary) state_nx = IDLE;
        default: state_nx = IDLE;
      endcase
    end
  end

  // Outputs decoded from state; ready also drops combinationally on ESTOP or reset
  always_comb begin
    CMD_READY = (state == IDLE) && !RST && !ESTOP;
    BUSY      = (state == RAMP);
  end

  // Duty datapath: target capture on accept, CCR slewing once per boundary, DONE pulse
  always_ff @(posedge CLK) begin
    if (RST) begin
      CCR    <= '0;
      target <= '0;
      DONE   <= 1'b0;
    end else if (ESTOP) begin
      CCR    <= '0;
      target <= '0;
      DONE   <= 1'b0;
    end else begin
      DONE <= 1'b0;
      case (state)
        IDLE: begin
          if (accept) begin
            target <= duty_clamped;
          end
        end
        RAMP: begin
          if (boundary) begin
            if (near) begin
              CCR  <= target;
              DONE <= 1'b1;
            end else if (tgt8 > ccr8) begin
              CCR <= CW'(ccr8 + STEP8);
            end else begin
              CCR <= CW'(ccr8 - STEP8);
            end
          end
        end
        STOP: begin
          CCR    <= '0;
          target <= '0;
        end
        default: begin
          CCR    <= '0;
          target <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_pwm_duty_ramp_ctrl.sv
// tb/tb_pwm_duty_ramp_ctrl.sv - scoreboard bench for pwm_duty_ramp_ctrl (PERIOD=100, STEP=5, PRESCALE=3 under PWM_PRESCALE_EN)
module tb_pwm_duty_ramp_ctrl;

  localparam int P = 100;
  localparam int S = 5;
`ifdef PWM_PRESCALE_EN
  localparam int PS = 3;
`else
  localparam int PS = 1;
`endif
  localparam int BOUND = 12000;

  logic       clk;
  logic       RST;
  logic       CMD_VALID;
  logic       CMD_READY;
  logic [6:0] CMD_DUTY;
  logic       ESTOP;
  logic [6:0] TCR;
  logic       E;
  logic [6:0] CCR;
  logic       BUSY;
  logic       DONE;

  pwm_duty_ramp_ctrl #(
    .PERIOD   (P),
    .STEP     (S),
    .PRESCALE (3)
  ) dut (
    .CLK       (clk),
    .RST       (RST),
    .CMD_VALID (CMD_VALID),
    .CMD_READY (CMD_READY),
    .CMD_DUTY  (CMD_DUTY),
    .ESTOP     (ESTOP),
    .TCR       (TCR),
    .E         (E),
    .CCR       (CCR),
    .BUSY      (BUSY),
    .DONE      (DONE)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int ccr;
    bit aligned;
  } exp_t;

  exp_t ccr_q[$];
  int   done_q[$];
  int   n_checks = 0;
  int   n_fail   = 0;
  bit   ramping  = 0;
  bit   stopped  = 0;
  bit   mon_en   = 0;
  int   last_ccr = 0;
  int   m_tcr    = 0;
  int   m_pre    = 0;
  int   cur      = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference timebase
  always @(posedge clk) begin
    if (RST) begin
      m_tcr <= 0;
      m_pre <= 0;
    end else if (m_pre == PS - 1) begin
      m_pre <= 0;
      m_tcr <= (m_tcr == P - 1) ? 0 : m_tcr + 1;
    end else begin
      m_pre <= m_pre + 1;
    end
  end

  // Monitor: per-cycle timebase/handshake checks, pops CCR and DONE expectations
  always @(negedge clk) begin : mon
    exp_t e;
    int   d;
    bit   er;
    bit   leave;
    if (mon_en) begin
      if (RST) begin
        ramping = 0;
        stopped = 0;
      end
      check("tcr", TCR, m_tcr);
      check("e", E, m_tcr == 0);
      if (CCR !== last_ccr[6:0]) begin
        if (ccr_q.size() == 0) begin
          check("ccr_unexpected", CCR, last_ccr);
        end else begin
          e = ccr_q.pop_front();
          check("ccr_step", CCR, e.ccr);
          if (e.aligned) check("ccr_align_tcr", TCR, 0);
        end
        last_ccr = int'(CCR);
      end
      if (DONE === 1'b1) begin
        if (done_q.size() == 0) begin
          check("done_unexpected", DONE, 0);
        end else begin
          d = done_q.pop_front();
          check("done_ccr", CCR, d);
          ramping = 0;
        end
      end
      leave = stopped && !ESTOP && (m_pre == PS - 1) && (m_tcr == P - 1);
      er = !RST && !ramping && !stopped && !ESTOP;
      check("cmd_ready", CMD_READY, er);
      check("busy", BUSY, ramping);
      if (ESTOP) begin
        stopped = 1;
        ramping = 0;
      end else if (leave) begin
        stopped = 0;
      end else if (CMD_VALID && er) begin
        ramping = 1;
      end
    end
  end

  task automatic push_ramp(input int from, input int to);
    int c;
    c = from;
    while (c != to) begin
      if (((to > c) ? to - c : c - to) <= S) c = to;
      else if (to > c) c = c + S;
      else c = c - S;
      ccr_q.push_back('{c, 1'b1});
    end
    done_q.push_back(to);
  endtask

  task automatic issue(input int duty);
    @(posedge clk);
    #2;
    CMD_VALID = 1'b1;
    CMD_DUTY  = 7'(duty);
    @(posedge clk);
    #2;
    CMD_VALID = 1'b0;
  endtask

  task automatic wait_idle(input string name);
    int k;
    k = 0;
    while ((ccr_q.size() != 0 || done_q.size() != 0 || ramping || stopped) && k < BOUND) begin
      @(posedge clk);
      k++;
    end
    check(name, k < BOUND, 1);
  endtask

  task automatic wait_tcr(input int v);
    int k;
    k = 0;
    do begin
      @(posedge clk);
      #2;
      k++;
    end while (m_tcr != v && k < BOUND);
    check("wait_tcr_timeout", k < BOUND, 1);
  endtask

  initial begin : stim
    int k;
    RST       = 1'b1;
    CMD_VALID = 1'b0;
    CMD_DUTY  = '0;
    ESTOP     = 1'b0;

    @(posedge clk);
    #2;
    mon_en   = 1;
    last_ccr = 0;
    check("rst_ccr", CCR, 0);
    check("rst_tcr", TCR, 0);
    check("rst_e", E, 1);
    check("rst_busy", BUSY, 0);
    check("rst_done", DONE, 0);
    check("rst_ready_low", CMD_READY, 0);
    @(posedge clk);
    #2;
    RST = 1'b0;
    #1;
    check("ready_after_rst", CMD_READY, 1);

    // Idle across more than one full period: wrap and E checked by the monitor
    repeat (150 * PS) @(posedge clk);

    // Mid-period command 20 ramps 5,10,15,20
    wait_tcr(37);
    issue(20);
    push_ramp(0, 20);
    wait_idle("ramp_up_20");

    // Down to 8: 15,10,8
    issue(8);
    push_ramp(20, 8);
    wait_idle("ramp_down_8");

    // Same target: one boundary then DONE, no CCR change
    issue(8);
    push_ramp(8, 8);
    wait_idle("same_target");

    // Clamped command 120 -> 100, with CMD_VALID held; command 0 accepted on return to IDLE
    push_ramp(8, 100);
    push_ramp(100, 0);
    @(posedge clk);
    #2;
    CMD_VALID = 1'b1;
    CMD_DUTY  = 7'd120;
    @(posedge clk);
    #2;
    CMD_DUTY = 7'd0;
    k = 0;
    while (done_q.size() != 1 && k < BOUND) begin
      @(posedge clk);
      k++;
    end
    check("held_valid_timeout", k < BOUND, 1);
    #2;
    CMD_VALID = 1'b0;
    wait_idle("held_second_cmd");

    // ESTOP at CCR=15 while ramping to 40
    issue(40);
    ccr_q.push_back('{5, 1'b1});
    ccr_q.push_back('{10, 1'b1});
    ccr_q.push_back('{15, 1'b1});
    k = 0;
    while (ccr_q.size() != 0 && k < BOUND) begin
      @(posedge clk);
      k++;
    end
    check("estop_pre_timeout", k < BOUND, 1);
    wait_tcr(50);
    ccr_q.push_back('{0, 1'b0});
    ESTOP     = 1'b1;
    CMD_VALID = 1'b1;
    CMD_DUTY  = 7'd33;
    @(posedge clk);
    #2;
    ESTOP     = 1'b0;
    CMD_VALID = 1'b0;
    check("estop_ccr_zero", CCR, 0);
    check("estop_tcr_nonzero", TCR == 0, 0);
    wait_idle("estop_exit");

    // Normal operation resumes after STOP
    issue(10);
    push_ramp(0, 10);
    wait_idle("post_estop_ramp");

    repeat (3) @(posedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/pwm_duty_ramp_ctrl.md
Name: pwm_duty_ramp_ctrl

Overview:
Owns the PWM timebase and sequences the compare value for the motor PWM output stage. It drives the 7-bit TCR counter, the TCR-zero enable E, and the CCR duty register. It accepts duty-change commands over a valid/ready handshake and slews CCR toward the target by a fixed step once per PWM period, so the motor never sees a mid-period duty change. It also provides an emergency stop that forces 0% duty.

Parameters:
PERIOD, 100, PWM period in TCR counts; TCR runs 0..PERIOD-1; legal range 2..127
STEP, 1, maximum CCR change per PWM period; legal range 1..PERIOD
PRESCALE, 1, CLK cycles per TCR count; used only when PWM_PRESCALE_EN is defined; legal range 1..255

Ports:
CLK  in  1  system clock, rising edge
RST  in  1  synchronous active-high reset
CMD_VALID  in  1  duty command valid
CMD_READY  out  1  controller can accept a command
CMD_DUTY  in  7  target duty in TCR counts; values above PERIOD are clamped to PERIOD
ESTOP  in  1  level emergency stop
TCR  out  7  timer count to the PWM output stage
E  out  1  TCR-zero enable; combinational, TCR==0
CCR  out  7  compare value to the PWM output stage
BUSY  out  1  ramp in progress (state RAMP)
DONE  out  1  one-cycle pulse when CCR reaches the target

Behaviour:
- Reset (RST high at a CLK edge): TCR=0, CCR=0, target=0, state=IDLE, DONE=0. Resulting outputs: BUSY=0, E=1, CMD_READY=1 once RST is low. CMD_READY is forced to 0 while RST is high. Reset mid-ramp abandons the ramp with no DONE.
- Timebase: TCR increments by 1 on each tick.
  - Tick = every CLK cycle, or per the prescaler (see Optional Feature).
  - TCR wraps from PERIOD-1 to 0.
- Boundary cycle: the tick cycle in which TCR==PERIOD-1. CCR changes only on the edge ending a boundary cycle, so a new CCR takes effect together with TCR=0.
  - Exception: ESTOP.
- States:
  - IDLE: CMD_READY=1.
    - Handshake: a command is accepted on a CLK edge with CMD_VALID&CMD_READY.
    - On accept: target <= min(CMD_DUTY, PERIOD), then go to RAMP.
    - CMD_DUTY is sampled only at accept.
  - RAMP: CMD_READY=0, BUSY=1. At each boundary:
    - If |target-CCR| <= STEP: CCR <= target, DONE=1 for the next cycle, go to IDLE.
    - Otherwise: CCR <= CCR+STEP if target>CCR, else CCR <= CCR-STEP.
    - Target equal to the current CCR still waits one boundary and then pulses DONE.
  - STOP: CMD_READY=0, BUSY=0, CCR held at 0.
    - Leave STOP at the first boundary where ESTOP is low; go to IDLE with target=0 and no DONE.
- ESTOP: takes priority over everything except RST.
  - Any state with ESTOP high at a CLK edge: CCR <= 0, target <= 0, state <= STOP. This is immediate and not boundary-aligned.
  - A command presented in that same cycle is not accepted, because CMD_READY is driven 0 combinationally when ESTOP is high.
  - ESTOP wins over a simultaneous DONE: DONE is suppressed.
- Arithmetic:
  - Use 8-bit internal add/subtract so that CCR+STEP never wraps.
  - CCR is always within 0..PERIOD.
  - CCR==PERIOD gives 100% duty, because TCR never equals CCR.
  - CCR==0 gives 0% duty.
- TCR and E are free-running in every state except reset.

Optional Feature:
Macro PWM_PRESCALE_EN.
- Defined: an 8-bit prescale counter generates a tick every PRESCALE CLK cycles.
  - The counter is reset to 0 by RST; a tick occurs when it equals PRESCALE-1, then it wraps.
  - TCR holds between ticks.
  - E stays high for all PRESCALE cycles of TCR==0.
  - The boundary cycle is the single tick cycle with TCR==PERIOD-1.
- Undefined: tick=1 every cycle, no prescale counter; PRESCALE is ignored.

Decomposition:
- Shared package pwm_pkg:
  - TCR/CCR width constant (7)
  - state enum (IDLE, RAMP, STOP)
  - default PERIOD/STEP constants
- One natural sub-module: pwm_timebase. It contains TCR, the optional prescaler, and the E and boundary strobes.
- The ramp FSM stays in the top module.

Test Plan:
- Reset then idle, PERIOD=100 → TCR counts 0..99 and wraps; E=1 only at TCR=0; CCR=0; CMD_READY=1.
- STEP=5, command 20 accepted mid-period → CCR becomes 5, 10, 15, 20 at four successive TCR 99→0 transitions; BUSY high throughout; DONE one pulse with CCR=20; CMD_READY returns to 1.
- STEP=5, CCR=20, command 8 → CCR becomes 15, 10, then 8 at the third boundary; DONE pulses.
- Command 120 with PERIOD=100, STEP=100 → CCR=100 after one boundary.
- CMD_VALID held high while BUSY → no accept until IDLE; a second command 0 is accepted the cycle CMD_READY=1.
- ESTOP pulse while CCR=15 ramping to 40 → CCR=0 the next cycle (TCR≠0); DONE never pulses. After ESTOP drops, IDLE is reached at the next boundary.
- With PWM_PRESCALE_EN and PRESCALE=3 → TCR advances every 3 CLK; E high for 3 cycles; one CCR step per boundary.
